frontend_cmd_dispatch_queue: RTL and testbench
==============================================

Name: frontend_cmd_dispatch_queue

Overview:
- Sits directly upstream of the backend controller top. It takes scheduled requests from the frontend scheduler and drives the backend command channel and the write-data read channel.
- A command FIFO buffers commands. A paired write-data FIFO holds burst data until the backend pulls it with its read-enable strobe.
- It decouples scheduler timing from backend ready/ren timing and flags protocol violations.

Parameters:
- CMD_W, 32: width of the frontend command word; matches the backend's FRONTEND_CMD_BITS.
- DATA_W, 128: width of the write-data word; matches DQ_BITS*8.
- CMD_DEPTH, 8: command FIFO entries; must be a power of 2 and at least 2.
- WDATA_DEPTH, 8: write-data FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- power_on_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  scheduler request valid.
- o_req_ready  out  1  queue can accept a request.
- i_req_command  in  CMD_W  command word.
- i_req_write  in  1  1 = write request; its data is carried on i_req_wdata.
- i_req_wdata  in  DATA_W  write burst data; ignored when i_req_write=0.
- o_frontend_command_valid  out  1  command valid to the backend.
- i_backend_controller_ready  in  1  backend accepts the command.
- o_frontend_command  out  CMD_W  head command word.
- o_frontend_write_data  out  DATA_W  head of the write-data FIFO.
- i_backend_controller_ren  in  1  backend consumes one write-data word.
- o_cmd_count  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy.
- o_pending_writes  out  $clog2(WDATA_DEPTH)+1  write-data FIFO occupancy.
- o_wdata_underflow  out  1  sticky error: ren was asserted while the write-data FIFO was empty.

Behaviour:
- Reset (asynchronous, power_on_rst_n=0):
  - Pointers and counts clear to 0.
  - o_frontend_command_valid=0, o_req_ready=0 while reset is asserted, o_wdata_underflow=0.
  - o_frontend_command and o_frontend_write_data read as 0.
  - Reset mid-operation discards all queued entries; no partial state survives.
- Ready:
  - o_req_ready = (cmd_count<CMD_DEPTH) && (wdata_count<WDATA_DEPTH).
  - It is conservative: it does not depend on i_req_write. It is combinational from registered counts only, so there is no valid-to-ready path.
- Push:
  - On i_req_valid && o_req_ready, the command is written to the command FIFO.
  - If i_req_write=1, i_req_wdata is written to the write-data FIFO in the same cycle.
- Command output:
  - First-word-fall-through from registered storage. o_frontend_command_valid = (cmd_count!=0).
  - A push into an empty queue is visible on the cycle after the push edge, so minimum latency is 1 cycle. There is no combinational input-to-output bypass.
- Command pop:
  - Occurs on o_frontend_command_valid && i_backend_controller_ready.
  - o_frontend_command must stay stable while valid is high and not accepted.
- Write-data pop:
  - On i_backend_controller_ren && wdata_count!=0, the read pointer advances and o_frontend_write_data shows the next entry.
  - Write data is always queued no later than its command, so the backend's ren (issued after command acceptance) normally finds data present.
- Underflow:
  - ren with wdata_count==0 causes no pointer change and sets o_wdata_underflow=1.
  - The flag stays set until reset.
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged and both pointers advance.
  - When full, ready is already 0, so there is no push-through on a same-cycle pop. Ready rises on the cycle after a pop.
  - Command pop and write-data pop are independent and may coincide.
- Pointers:
  - $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Wrap-around is natural binary overflow.
  - Counts are pointer differences, computed in pointer width.

Optional Feature:
- FRONTEND_QUEUE_STATS_EN:
  - Adds outputs o_stat_reads[31:0], o_stat_writes[31:0] and o_stat_stall_cycles[31:0].
  - o_stat_reads / o_stat_writes count accepted requests with i_req_write=0 / 1.
  - o_stat_stall_cycles counts cycles with o_frontend_command_valid && !i_backend_controller_ready.
  - Counters saturate at all-ones and reset to 0.
  - Without the macro, these ports and counters do not exist.

Decomposition:
- Shared package frontend_queue_pkg holds:
  - CMD_W and DATA_W defaults, tied to the FRONTEND_CMD_BITS and DQ_BITS macros.
  - A ptr_t width helper function.
- One sub-module, sync_fwft_fifo (parameterised WIDTH and DEPTH; push, pop, count, head), instantiated twice: once for commands, once for write data.

Test Plan:
- Single read: push cmd 0x0000_1234 with write=0 and backend ready held high → valid rises 1 cycle after push, command pops next edge; o_pending_writes stays 0.
- Write with delayed ren: push a write with wdata 0xA5…A5 and accept the command → o_pending_writes=1; ren 3 cycles later → data 0xA5…A5 present at ren, count returns to 0.
- Fill: backend ready=0, push 8 writes → o_req_ready=0 after the 8th with o_cmd_count=8; one pop → ready=1 on the following cycle.
- Backpressure stability: valid with ready=0 for 5 cycles → o_frontend_command is unchanged every cycle; FIFO order is preserved across wrap-around using 20 sequential commands.
- Underflow: assert ren with an empty write-data FIFO → o_wdata_underflow=1 next cycle and pointers unchanged; the flag stays set until power_on_rst_n pulses low.
- Reset mid-stream: reset with 5 entries queued → all counts 0, valid 0, flag 0; the first push after reset is delivered correctly.

Source files
------------

// File: rtl/frontend_queue_pkg.sv
// Shared defaults and helpers for the frontend command dispatch queue.
// Data widths follow the FRONTEND_CMD_BITS and DQ_BITS macros when they are defined.
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 16
`endif

package frontend_queue_pkg;

  localparam int FRONTEND_CMD_W  = `FRONTEND_CMD_BITS;
  localparam int FRONTEND_DATA_W = `DQ_BITS * 8;

  // Pointer width for a power-of-two FIFO; the extra MSB separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word-fall-through FIFO with registered storage and wrap-bit pointers.
// The head reads as zero whenever the FIFO is empty.
module sync_fwft_fifo
  import frontend_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             empty, full;
  logic             push_ok, pop_ok;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty   = (count_o == '0);
  assign full    = (count_o == DEPTH_C);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE_C;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries data only, so it is left out of reset; emptiness masks stale words.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign head_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/frontend_cmd_dispatch_queue.sv
// Command and write-data queue between the frontend scheduler and the backend controller.
// Define FRONTEND_QUEUE_STATS_EN to add saturating read/write/stall statistics outputs.
module frontend_cmd_dispatch_queue
  import frontend_queue_pkg::*;
#(
  parameter int CMD_W       = FRONTEND_CMD_W,
  parameter int DATA_W      = FRONTEND_DATA_W,
  parameter int CMD_DEPTH   = 8,
  parameter int WDATA_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          power_on_rst_n,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [CMD_W-1:0]              i_req_command,
  input  logic                          i_req_write,
  input  logic [DATA_W-1:0]             i_req_wdata,
  output logic                          o_frontend_command_valid,
  input  logic                          i_backend_controller_ready,
  output logic [CMD_W-1:0]              o_frontend_command,
  output logic [DATA_W-1:0]             o_frontend_write_data,
  input  logic                          i_backend_controller_ren,
  output logic [$clog2(CMD_DEPTH):0]    o_cmd_count,
  output logic [$clog2(WDATA_DEPTH):0]  o_pending_writes,
  output logic                          o_wdata_underflow
`ifdef FRONTEND_QUEUE_STATS_EN
  ,
  output logic [31:0]                   o_stat_reads,
  output logic [31:0]                   o_stat_writes,
  output logic [31:0]                   o_stat_stall_cycles
`endif
);

  localparam int CPW = ptr_w(CMD_DEPTH);
  localparam int WPW = ptr_w(WDATA_DEPTH);
  localparam logic [CPW-1:0] CMD_FULL_C   = CPW'(CMD_DEPTH);
  localparam logic [WPW-1:0] WDATA_FULL_C = WPW'(WDATA_DEPTH);

  logic req_push, wdata_push;
  logic cmd_pop, wdata_pop;
  logic wdata_empty;
  logic underflow_q, underflow_d;

  // Ready depends only on registered occupancy (and reset), never on the request itself.
  assign o_req_ready = power_on_rst_n
                    && (o_cmd_count < CMD_FULL_C)
                    && (o_pending_writes < WDATA_FULL_C);

  assign req_push   = i_req_valid && o_req_ready;
  assign wdata_push = req_push && i_req_write;

  assign o_frontend_command_valid = (o_cmd_count != '0);
  assign cmd_pop     = o_frontend_command_valid && i_backend_controller_ready;
  assign wdata_empty = (o_pending_writes == '0);
  assign wdata_pop   = i_backend_controller_ren && !wdata_empty;

  sync_fwft_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (power_on_rst_n),
    .push_i  (req_push),
    .data_i  (i_req_command),
    .pop_i   (cmd_pop),
    .count_o (o_cmd_count),
    .head_o  (o_frontend_command)
  );

  sync_fwft_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (WDATA_DEPTH)
  ) u_wdata_fifo (
    .clk     (clk),
    .rst_n   (power_on_rst_n),
    .push_i  (wdata_push),
    .data_i  (i_req_wdata),
    .pop_i   (wdata_pop),
    .count_o (o_pending_writes),
    .head_o  (o_frontend_write_data)
  );

  // Underflow is sticky: once the backend reads an empty data queue, only reset clears it.
  always_comb begin
    underflow_d = underflow_q;
    if (i_backend_controller_ren && wdata_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) underflow_q <= 1'b0;
    else                 underflow_q <= underflow_d;
  end

  assign o_wdata_underflow = underflow_q;

`ifdef FRONTEND_QUEUE_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
    if (en && (val != '1)) return val + 32'd1;
    return val;
  endfunction

  logic [31:0] stat_reads_q,  stat_reads_d;
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [31:0] stat_stall_q,  stat_stall_d;

  always_comb begin
    stat_reads_d  = sat_inc32(stat_reads_q,  req_push && !i_req_write);
    stat_writes_d = sat_inc32(stat_writes_q, req_push &&  i_req_write);
    stat_stall_d  = sat_inc32(stat_stall_q,
                              o_frontend_command_valid && !i_backend_controller_ready);
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign o_stat_reads        = stat_reads_q;
  assign o_stat_writes       = stat_writes_q;
  assign o_stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_frontend_cmd_dispatch_queue.sv
// Directed bench for frontend_cmd_dispatch_queue: a queue-based reference model checked
// every cycle, plus literal expectations along the test sequence.
module tb_frontend_cmd_dispatch_queue;

  localparam int CW = 32;
  localparam int DW = 128;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CW-1:0] req_cmd = '0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          cmd_valid;
  logic          bk_ready = 1'b0;
  logic [CW-1:0] cmd_out;
  logic [DW-1:0] wdata_out;
  logic          bk_ren = 1'b0;
  logic [3:0]    cmd_count;
  logic [3:0]    pending;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] cq[$];
  logic [DW-1:0] wq[$];
  logic          m_uf;

  frontend_cmd_dispatch_queue dut (
    .clk                        (clk),
    .power_on_rst_n             (rst_n),
    .i_req_valid                (req_valid),
    .o_req_ready                (req_ready),
    .i_req_command              (req_cmd),
    .i_req_write                (req_write),
    .i_req_wdata                (req_wdata),
    .o_frontend_command_valid   (cmd_valid),
    .i_backend_controller_ready (bk_ready),
    .o_frontend_command         (cmd_out),
    .o_frontend_write_data      (wdata_out),
    .i_backend_controller_ren   (bk_ren),
    .o_cmd_count                (cmd_count),
    .o_pending_writes           (pending),
    .o_wdata_underflow          (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: two plain queues and a sticky flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq.delete();
      wq.delete();
      m_uf <= 1'b0;
    end else begin
      automatic bit rdy  = (cq.size() < DEPTH) && (wq.size() < DEPTH);
      automatic bit cpop = (cq.size() != 0) && bk_ready;
      automatic bit wpop = bk_ren && (wq.size() != 0);
      automatic bit uf   = bk_ren && (wq.size() == 0);
      if (cpop) void'(cq.pop_front());
      if (wpop) void'(wq.pop_front());
      if (req_valid && rdy) begin
        cq.push_back(req_cmd);
        if (req_write) wq.push_back(req_wdata);
      end
      if (uf) m_uf <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ready", req_ready, rst_n && (cq.size() < DEPTH) && (wq.size() < DEPTH));
    chk("cmd_valid", cmd_valid, cq.size() != 0);
    chk("cmd", cmd_out, (cq.size() != 0) ? cq[0] : '0);
    chk("wdata", wdata_out, (wq.size() != 0) ? wq[0] : '0);
    chk("cmd_count", cmd_count, cq.size());
    chk("pending", pending, wq.size());
    chk("underflow", underflow, m_uf);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic w, input logic [DW-1:0] d);
    req_valid = 1'b1; req_cmd = c; req_write = w; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    repeat (3) tick();
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_valid", cmd_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single read request with the backend always ready
    bk_ready = 1'b1;
    push(32'h0000_1234, 1'b0, '0);
    chk("rd_valid", cmd_valid, 1'b1);
    chk("rd_cmd", cmd_out, 32'h0000_1234);
    tick();
    chk("rd_popped", cmd_valid, 1'b0);
    chk("rd_pending", pending, 4'd0);

    // Write whose data is pulled three cycles later
    push(32'h2000_0001, 1'b1, a5);
    chk("wr_pending", pending, 4'd1);
    repeat (3) tick();
    chk("wr_cmd_gone", cmd_valid, 1'b0);
    chk("wr_data", wdata_out, a5);
    bk_ren = 1'b1;
    tick();
    bk_ren = 1'b0;
    chk("wr_drained", pending, 4'd0);
    chk("wr_no_uf", underflow, 1'b0);

    // Fill both queues, try one more, then free a slot
    bk_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h3000_0000 + i, 1'b1, DW'(i));
    chk("full_ready", req_ready, 1'b0);
    chk("full_count", cmd_count, 4'd8);
    push(32'h0000_DEAD, 1'b0, '0);
    chk("full_hold", cmd_count, 4'd8);
    bk_ready = 1'b1; bk_ren = 1'b1;
    tick();
    bk_ready = 1'b0; bk_ren = 1'b0;
    chk("pop_count", cmd_count, 4'd7);
    chk("pop_ready", req_ready, 1'b1);
    chk("pop_head", cmd_out, 32'h3000_0001);
    chk("pop_wdata", wdata_out, 128'd1);
    bk_ready = 1'b1; bk_ren = 1'b1;
    repeat (7) tick();
    bk_ready = 1'b0; bk_ren = 1'b0;
    chk("drain_count", cmd_count, 4'd0);
    chk("drain_pending", pending, 4'd0);

    // Backpressure holds the head, then a streaming run wraps the pointers
    push(32'h0000_BEEF, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd", cmd_out, 32'h0000_BEEF);
      chk("bp_valid", cmd_valid, 1'b1);
      tick();
    end
    bk_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(32'h4000_0000 + i, 1'b0, '0);
      chk("wrap_head", cmd_out, 32'h4000_0000 + i);
      chk("wrap_count", cmd_count, 4'd1);
    end
    tick();
    chk("wrap_empty", cmd_valid, 1'b0);

    // Underflow on an empty data queue is sticky and moves no pointer
    bk_ren = 1'b1;
    tick();
    bk_ren = 1'b0;
    chk("uf_set", underflow, 1'b1);
    chk("uf_pending", pending, 4'd0);
    repeat (3) tick();
    chk("uf_sticky", underflow, 1'b1);
    push(32'h5000_0000, 1'b1, 128'h77);
    chk("uf_after_data", wdata_out, 128'h77);
    chk("uf_after_cnt", pending, 4'd1);
    bk_ren = 1'b1;
    tick();
    bk_ren = 1'b0;
    chk("uf_after_drain", pending, 4'd0);

    // Reset with five entries queued
    bk_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h6000_0000 + i, 1'b1, DW'(i + 16));
    chk("pre_rst_count", cmd_count, 4'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_count", cmd_count, 4'd0);
    chk("rst_pending", pending, 4'd0);
    chk("rst_valid2", cmd_valid, 1'b0);
    chk("rst_uf", underflow, 1'b0);
    chk("rst_cmd", cmd_out, '0);
    tick();
    tick();
    rst_n = 1'b1;
    push(32'h0000_CAFE, 1'b1, 128'hCAFE);
    chk("post_rst_cmd", cmd_out, 32'h0000_CAFE);
    chk("post_rst_data", wdata_out, 128'hCAFE);
    chk("post_rst_count", cmd_count, 4'd1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
